sio_cmd_sched: RTL and testbench

SIO_CMD_SCHED -- requirements
Module: sio_cmd_sched

---
 rtl/sio_pkg.sv | 23 ++
 rtl/sio_cmd_sched_rr_arb.sv | 24 ++
 rtl/sio_cmd_sched.sv | 110 +++++++++++
 tb/tb_sio_cmd_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sio_pkg.sv
// Shared constants, command layout and FSM encoding for the serial command scheduler.
package sio_pkg;
  localparam int          FRAME_DEF    = 128;
  localparam int          RSP_WIN_DEF  = 120;
  localparam logic [3:0]  NOP_ADDR_DEF = 4'hF;

  // 20-bit command word: addr in [19:16], write data in [15:0]
  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AWAIT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic cmd_t mk_cmd(input logic [3:0] a, input logic [15:0] d);
    mk_cmd.addr  = a;
    mk_cmd.wdata = d;
  endfunction
endpackage

// File: rtl/sio_cmd_sched_rr_arb.sv
// Combinational round-robin arbiter: search begins one past the last-granted index.
module rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt
);
  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sio_cmd_sched.sv
// Frame-based command scheduler: one arbitrated command per serial frame, routes the
// read-back word to the granted requester or flags a timeout.
module sio_cmd_sched
  import sio_pkg::*;
#(
  parameter int         NREQ     = 4,
  parameter int         FRAME    = FRAME_DEF,
  parameter int         RSP_WIN  = RSP_WIN_DEF,
  parameter logic [3:0] NOP_ADDR = NOP_ADDR_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [4*NREQ-1:0]  req_addr,
  input  logic [16*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]    gnt,
  output logic               frame_start,
  output logic [19:0]        cmd,
  input  logic               resp_valid,
  input  logic [15:0]        resp_data,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [15:0]        rsp_data,
  output logic [NREQ-1:0]    rsp_err,
  output logic               busy
);
  localparam int             CW      = $clog2(FRAME);
  localparam int             PW      = $clog2(NREQ);
  localparam logic [CW-1:0]  CNT_MAX = CW'(FRAME - 1);
  localparam logic [CW-1:0]  WIN     = CW'(RSP_WIN);
  localparam logic [CW-1:0]  TMO     = CW'(RSP_WIN + 1);

  logic [CW-1:0]   cnt;
  logic [PW-1:0]   ptr, gidx;
  logic [NREQ-1:0] arb_gnt, own_oh;
  logic            frame0, any_gnt, accept, timeout;
  cmd_t            sel_cmd, cmd_q;
  state_t          state_q, state, state_nxt;

  rr_arb #(.N(NREQ)) u_arb (
    .req  (req),
    .last (ptr),
    .gnt  (arb_gnt)
  );

  assign frame0  = !reset && (cnt == '0);
  assign any_gnt = |arb_gnt;
  // ptr doubles as the owner of the frame in flight: it only moves on a real grant
  assign own_oh  = NREQ'(1) << ptr;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++)
      if (arb_gnt[i]) gidx = PW'(i);
  end

  always_comb begin
    sel_cmd = mk_cmd(NOP_ADDR, 16'h0000);
    if (any_gnt) sel_cmd = mk_cmd(req_addr[4*gidx +: 4], req_wdata[16*gidx +: 16]);
  end

  // Frame boundary decides the state combinationally so gnt, cmd and busy line up at count 0.
  always_comb begin
    state = state_q;
    if (reset)       state = ST_IDLE;
    else if (frame0) state = any_gnt ? ST_AWAIT : ST_IDLE;
  end

  assign accept  = (state == ST_AWAIT) && resp_valid && !frame0 && (cnt <= WIN);
  assign timeout = (state == ST_AWAIT) && (cnt == TMO);

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_AWAIT: if (accept || timeout) state_nxt = ST_DONE;
      default:  ;
    endcase
  end

  // FSM: outputs
  always_comb begin
    frame_start = frame0;
    gnt         = frame0 ? arb_gnt : '0;
    cmd         = frame0 ? sel_cmd : cmd_q;
    busy        = (state == ST_AWAIT);
    rsp_err     = timeout ? own_oh : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      ptr       <= PW'(NREQ - 1);
      cmd_q     <= mk_cmd(NOP_ADDR, 16'h0000);
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      cnt       <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
      if (frame0) cmd_q <= sel_cmd;
      if (frame0 && any_gnt) ptr <= gidx;
      rsp_valid <= accept ? own_oh : '0;
      if (accept) rsp_data <= resp_data;
    end
  end
endmodule

// File: tb/tb_sio_cmd_sched.sv
// Bench for sio_cmd_sched: frame table plus hand sequences, grant/response scoreboards.
module tb_sio_cmd_sched;
  localparam int NREQ = 4, FRAME = 128, RSP_WIN = 120;

  logic        clock = 1'b0, reset = 1'b1;
  logic [3:0]  req;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  gnt, rsp_valid, rsp_err;
  logic        frame_start, busy, resp_valid;
  logic [19:0] cmd;
  logic [15:0] resp_data, rsp_data;

  sio_cmd_sched #(.NREQ(NREQ), .FRAME(FRAME), .RSP_WIN(RSP_WIN), .NOP_ADDR(4'hF)) dut (
    .clock(clock), .reset(reset), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .frame_start(frame_start), .cmd(cmd), .resp_valid(resp_valid),
    .resp_data(resp_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct { logic [3:0] req; logic [3:0] gnt; logic [19:0] cmd; logic busy; } vec_t;
  typedef struct { logic [3:0] mask; int gap; } gexp_t;
  typedef struct { logic is_err; logic [3:0] mask; logic [15:0] data; int at; } ev_t;

  int    n_cmp = 0, n_bad = 0;
  int    tb_cnt = 0, cyc = 0, last_gcyc = 0;
  gexp_t gq[$];
  ev_t   eq[$];
  vec_t  vt[7];
  logic [15:0] wd[4];

  always @(posedge clock) begin
    cyc    <= cyc + 1;
    tb_cnt <= reset ? 0 : ((tb_cnt == FRAME - 1) ? 0 : tb_cnt + 1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cnt %0d)", nm, act, exp, tb_cnt);
    end
  endtask

  // Scoreboard monitor: every grant and every response/error pulse must match a queued expectation.
  always @(negedge clock) begin
    gexp_t g;
    ev_t   e;
    if (!reset) begin
      chk("frame_start", 32'(frame_start), 32'(tb_cnt == 0));
      if (gnt != 0) begin
        if (gq.size() == 0) chk("gnt_unexpected", 32'(gnt), 32'h0);
        else begin
          g = gq.pop_front();
          chk("gnt_mask", 32'(gnt), 32'(g.mask));
          chk("gnt_cnt", 32'(tb_cnt), 32'h0);
          if (g.gap != 0) chk("gnt_gap", 32'(cyc - last_gcyc), 32'(g.gap));
        end
        last_gcyc = cyc;
      end
      if (rsp_valid != 0 || rsp_err != 0) begin
        if (eq.size() == 0) chk("rsp_unexpected", 32'({rsp_valid, rsp_err}), 32'h0);
        else begin
          e = eq.pop_front();
          chk("rsp_valid", 32'(rsp_valid), e.is_err ? 32'h0 : 32'(e.mask));
          chk("rsp_err", 32'(rsp_err), e.is_err ? 32'(e.mask) : 32'h0);
          chk("rsp_cnt", 32'(tb_cnt), 32'(e.at));
          if (!e.is_err) chk("rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end
    end
  end

  // Advance to the cycle holding frame count c (inputs driven 1 time unit after the edge).
  task automatic at_cnt(input int c);
    do begin
      @(posedge clock);
      #1;
    end while (tb_cnt != c);
  endtask

  task automatic push_err(input logic [3:0] m);
    eq.push_back('{is_err: 1'b1, mask: m, data: 16'h0, at: RSP_WIN + 1});
  endtask

  task automatic launch(input bit drv, input logic [3:0] r, input logic [3:0] g, input logic [19:0] c);
    at_cnt(FRAME - 4);
    if (drv) req = r;
    at_cnt(0);
    if (g != 0) gq.push_back('{mask: g, gap: 0});
    @(negedge clock);
    chk("launch_gnt", 32'(gnt), 32'(g));
    chk("launch_cmd", 32'(cmd), 32'(c));
    chk("launch_busy", 32'(busy), 32'(g != 0));
    at_cnt(1);
    req = '0;
  endtask

  initial begin
    req = '0; resp_valid = 1'b0; resp_data = '0;
    wd[0] = 16'hA5A0; wd[1] = 16'h5A51; wd[2] = 16'h1234; wd[3] = 16'hC3C3;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[4*i +: 4]   = 4'(i);
      req_wdata[16*i +: 16] = wd[i];
    end
    vt[0] = '{4'b0100, 4'b0100, 20'h21234, 1'b1};
    vt[1] = '{4'b0000, 4'b0000, 20'hF0000, 1'b0};
    vt[2] = '{4'b1011, 4'b1000, 20'h3C3C3, 1'b1};
    vt[3] = '{4'b1011, 4'b0001, 20'h0A5A0, 1'b1};
    vt[4] = '{4'b0101, 4'b0100, 20'h21234, 1'b1};
    vt[5] = '{4'b0011, 4'b0001, 20'h0A5A0, 1'b1};
    vt[6] = '{4'b0010, 4'b0010, 20'h15A51, 1'b1};

    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    chk("rst_cmd", 32'(cmd), 32'hF0000);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_fs", 32'(frame_start), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp", 32'({rsp_valid, rsp_err}), 32'h0);
    chk("rst_rdata", 32'(rsp_data), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rel_cmd", 32'(cmd), 32'hF0000);

    // Arbitration table: each granted frame times out since nobody answers
    foreach (vt[i]) begin
      if (vt[i].gnt != 0) push_err(vt[i].gnt);
      launch(1'b1, vt[i].req, vt[i].gnt, vt[i].cmd);
      at_cnt(64);
      @(negedge clock);
      chk("tbl_cmd_hold", 32'(cmd), 32'(vt[i].cmd));
      chk("tbl_busy_hold", 32'(busy), 32'(vt[i].busy));
    end

    // Response routed to requester 1; a second response in the same frame is dropped
    eq.push_back('{is_err: 1'b0, mask: 4'b0010, data: 16'hBEEF, at: 41});
    launch(1'b1, 4'b0010, 4'b0010, 20'h15A51);
    at_cnt(40); resp_valid = 1'b1; resp_data = 16'hBEEF;
    at_cnt(41); resp_valid = 1'b0;
    @(negedge clock);
    chk("a_busy", 32'(busy), 32'h0);
    chk("a_data", 32'(rsp_data), 32'hBEEF);
    at_cnt(50); resp_valid = 1'b1; resp_data = 16'hDEAD;
    at_cnt(51); resp_valid = 1'b0;
    @(negedge clock);
    chk("a_data_hold", 32'(rsp_data), 32'hBEEF);

    // Timeout for requester 3; late response after the window is ignored
    push_err(4'b1000);
    launch(1'b1, 4'b1000, 4'b1000, 20'h3C3C3);
    at_cnt(120);
    @(negedge clock);
    chk("b_busy_120", 32'(busy), 32'h1);
    at_cnt(122);
    @(negedge clock);
    chk("b_busy_122", 32'(busy), 32'h0);
    at_cnt(125); resp_valid = 1'b1; resp_data = 16'h5555;
    at_cnt(126); resp_valid = 1'b0;

    // Response at exactly RSP_WIN is accepted, no error
    eq.push_back('{is_err: 1'b0, mask: 4'b1000, data: 16'h0120, at: RSP_WIN + 1});
    launch(1'b1, 4'b1000, 4'b1000, 20'h3C3C3);
    at_cnt(RSP_WIN); resp_valid = 1'b1; resp_data = 16'h0120;
    at_cnt(RSP_WIN + 1); resp_valid = 1'b0;

    // NOP frame: stray response ignored; req 2 pulses mid-frame and drops before count 0
    launch(1'b1, 4'b0000, 4'b0000, 20'hF0000);
    req[2] = 1'b1;
    at_cnt(10); resp_valid = 1'b1; resp_data = 16'h7777;
    at_cnt(11); resp_valid = 1'b0;
    at_cnt(100); req[2] = 1'b0;
    launch(1'b0, 4'b0000, 4'b0000, 20'hF0000);
    req[1] = 1'b1;
    launch(1'b0, 4'b0000, 4'b0010, 20'h15A51);
    push_err(4'b0010);
    at_cnt(125);

    // Fresh reset, all requesters held: strict round robin one frame apart, then reset mid-AWAIT
    reset = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    req = 4'b1111;
    gq.push_back('{mask: 4'b0001, gap: 0});
    gq.push_back('{mask: 4'b0010, gap: FRAME});
    gq.push_back('{mask: 4'b0100, gap: FRAME});
    gq.push_back('{mask: 4'b1000, gap: FRAME});
    gq.push_back('{mask: 4'b0001, gap: FRAME});
    push_err(4'b0001); push_err(4'b0010); push_err(4'b0100); push_err(4'b1000);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (4) at_cnt(0);
    at_cnt(60);
    @(negedge clock);
    chk("f_busy_60", 32'(busy), 32'h1);
    @(posedge clock); #1;
    reset = 1'b1;
    req = '0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("f_rst_cmd", 32'(cmd), 32'hF0000);
    chk("f_rst_busy", 32'(busy), 32'h0);
    chk("f_rst_out", 32'({gnt, rsp_valid, rsp_err, 3'b000, frame_start}), 32'h0);
    chk("f_rst_rdata", 32'(rsp_data), 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("f_rel_fs", 32'(frame_start), 32'h1);
    chk("f_rel_busy", 32'(busy), 32'h0);
    at_cnt(125);

    chk("gq_drained", 32'(gq.size()), 32'h0);
    chk("eq_drained", 32'(eq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
